// File: rtl/ext_bus_sched_if.sv
// Request/response signals of the two bus requesters plus the P0/P2 pad-side signals
// of the external bus scheduler.
interface ext_bus_sched_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_done;
    logic [7:0]  fetch_data;
    logic        x_req;
    logic        x_we;
    logic [15:0] x_addr;
    logic [7:0]  x_wdata;
    logic        x_gnt;
    logic        x_done;
    logic [7:0]  x_rdata;
    logic [7:0]  p0_out;
    logic        p0_oe;
    logic [7:0]  p0_in;
    logic [7:0]  p2_out;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
    logic        busy;

    modport master (
        output fetch_req, fetch_addr, x_req, x_we, x_addr, x_wdata, p0_in,
        input  fetch_gnt, fetch_done, fetch_data, x_gnt, x_done, x_rdata,
               p0_out, p0_oe, p2_out, ale, psen_n, rd_n, wr_n, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, x_req, x_we, x_addr, x_wdata, p0_in,
        output fetch_gnt, fetch_done, fetch_data, x_gnt, x_done, x_rdata,
               p0_out, p0_oe, p2_out, ale, psen_n, rd_n, wr_n, busy
    );
endinterface

// File: rtl/ext_bus_sched.sv
// Multiplexed external bus scheduler: arbitrates instruction fetch vs MOVX and sequences
// each access as ADDR -> STRB -> HOLD, driving ALE, PSEN_n, RD_n, WR_n and P0/P2.
module ext_bus_sched #(
    parameter int unsigned ADDR_CYC = 2,
    parameter int unsigned STRB_CYC = 3
) (
    input  logic           clk,
    input  logic           reset,
    ext_bus_sched_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_STRB, ST_HOLD} state_t;
    typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;

    localparam logic [3:0] ADDR_LAST = 4'(ADDR_CYC - 1);
    localparam logic [3:0] STRB_LAST = 4'(STRB_CYC - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    op_t         op_reg, op_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic        last_x_reg, last_x_next;
    logic [7:0]  fetch_data_reg;
    logic [7:0]  x_rdata_reg;
    logic        pick_x;
    logic        strb_last;

    // On a tie the requester type that did not win last time gets the bus.
    assign pick_x    = bus.x_req && !(bus.fetch_req && last_x_reg);
    assign strb_last = (state_reg == ST_STRB) && (cnt_reg == STRB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= OP_FETCH;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            last_x_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            last_x_reg <= last_x_next;
        end
    end

    // Read data survives a reset that aborts an access; a reset applied from idle clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_reg == ST_IDLE) begin
                fetch_data_reg <= '0;
                x_rdata_reg    <= '0;
            end
        end else if (strb_last) begin
            if (op_reg == OP_FETCH) begin
                fetch_data_reg <= bus.p0_in;
            end else if (op_reg == OP_READ) begin
                x_rdata_reg <= bus.p0_in;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        last_x_next = last_x_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (bus.fetch_req || bus.x_req) begin
                    state_next = ST_ADDR;
                    if (pick_x) begin
                        op_next     = bus.x_we ? OP_WRITE : OP_READ;
                        addr_next   = bus.x_addr;
                        wdata_next  = bus.x_wdata;
                        last_x_next = 1'b1;
                    end else begin
                        op_next     = OP_FETCH;
                        addr_next   = bus.fetch_addr;
                        last_x_next = 1'b0;
                    end
                end
            end
            ST_ADDR: begin
                if (cnt_reg == ADDR_LAST) begin
                    state_next = ST_STRB;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_STRB: begin
                if (cnt_reg == STRB_LAST) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_HOLD: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        bus.ale    = 1'b0;
        bus.psen_n = 1'b1;
        bus.rd_n   = 1'b1;
        bus.wr_n   = 1'b1;
        bus.p0_oe  = 1'b0;
        bus.p0_out = '0;
        bus.p2_out = '0;
        case (state_reg)
            ST_ADDR: begin
                bus.ale    = 1'b1;
                bus.p0_oe  = 1'b1;
                bus.p0_out = addr_reg[7:0];
                bus.p2_out = addr_reg[15:8];
            end
            ST_STRB: begin
                bus.p2_out = addr_reg[15:8];
                case (op_reg)
                    OP_FETCH: bus.psen_n = 1'b0;
                    OP_READ:  bus.rd_n   = 1'b0;
                    OP_WRITE: begin
                        bus.wr_n   = 1'b0;
                        bus.p0_oe  = 1'b1;
                        bus.p0_out = wdata_reg;
                    end
                    default: ;
                endcase
            end
            ST_HOLD: begin
                // Write data stays on P0 one extra cycle for the RAM's hold time.
                bus.p2_out = addr_reg[15:8];
                if (op_reg == OP_WRITE) begin
                    bus.p0_oe  = 1'b1;
                    bus.p0_out = wdata_reg;
                end
            end
            default: ;
        endcase
    end

    assign bus.fetch_gnt  = (state_reg == ST_ADDR) && (cnt_reg == 4'd0) && (op_reg == OP_FETCH);
    assign bus.x_gnt      = (state_reg == ST_ADDR) && (cnt_reg == 4'd0) && (op_reg != OP_FETCH);
    assign bus.fetch_done = (state_reg == ST_HOLD) && (op_reg == OP_FETCH);
    assign bus.x_done     = (state_reg == ST_HOLD) && (op_reg != OP_FETCH);
    assign bus.fetch_data = fetch_data_reg;
    assign bus.x_rdata    = x_rdata_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_ext_bus_sched.sv
// Self-checking bench for ext_bus_sched: a default instance and an ADDR_CYC=STRB_CYC=1
// instance share stimulus and are each compared every cycle against a timeline model.
module tb_ext_bus_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, x_req, x_we;
    logic [15:0] fetch_addr, x_addr;
    logic [7:0]  x_wdata, p0_in;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    ext_bus_sched_if bus0 ();
    ext_bus_sched_if bus1 ();

    assign bus0.fetch_req = fetch_req;   assign bus1.fetch_req = fetch_req;
    assign bus0.fetch_addr = fetch_addr; assign bus1.fetch_addr = fetch_addr;
    assign bus0.x_req = x_req;           assign bus1.x_req = x_req;
    assign bus0.x_we = x_we;             assign bus1.x_we = x_we;
    assign bus0.x_addr = x_addr;         assign bus1.x_addr = x_addr;
    assign bus0.x_wdata = x_wdata;       assign bus1.x_wdata = x_wdata;
    assign bus0.p0_in = p0_in;           assign bus1.p0_in = p0_in;

    ext_bus_sched #(.ADDR_CYC(2), .STRB_CYC(3)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    ext_bus_sched #(.ADDR_CYC(1), .STRB_CYC(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic       fetch_gnt;
        logic       fetch_done;
        logic [7:0] fetch_data;
        logic       x_gnt;
        logic       x_done;
        logic [7:0] x_rdata;
        logic [7:0] p0_out;
        logic       p0_oe;
        logic [7:0] p2_out;
        logic       ale;
        logic       psen_n;
        logic       rd_n;
        logic       wr_n;
        logic       busy;
    } outs_t;

    outs_t o0, o1;
    assign o0 = {bus0.fetch_gnt, bus0.fetch_done, bus0.fetch_data, bus0.x_gnt, bus0.x_done,
                 bus0.x_rdata, bus0.p0_out, bus0.p0_oe, bus0.p2_out, bus0.ale, bus0.psen_n,
                 bus0.rd_n, bus0.wr_n, bus0.busy};
    assign o1 = {bus1.fetch_gnt, bus1.fetch_done, bus1.fetch_data, bus1.x_gnt, bus1.x_done,
                 bus1.x_rdata, bus1.p0_out, bus1.p0_oe, bus1.p2_out, bus1.ale, bus1.psen_n,
                 bus1.rd_n, bus1.wr_n, bus1.busy};

    // Access model: ph counts clocks since the grant edge (0..A-1 address, then S strobe, then hold).
    typedef struct {
        bit          active;
        int          ph;
        int          op;      // 0 fetch, 1 read, 2 write
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          last_x;
        logic [7:0]  fdata;
        logic [7:0]  xdata;
    } mdl_t;
    mdl_t m [2];

    function automatic int a_of(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int s_of(input int i); return (i == 0) ? 3 : 1; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input int i);
        int  a = a_of(i);
        int  s = s_of(i);
        bit  take_x;
        if (reset) begin
            if (!m[i].active) begin
                m[i].fdata = 8'h00;
                m[i].xdata = 8'h00;
            end
            m[i].active = 1'b0;
            m[i].last_x = 1'b0;
        end else if (m[i].active) begin
            if (m[i].ph == a + s - 1) begin
                if (m[i].op == 0) m[i].fdata = p0_in;
                else if (m[i].op == 1) m[i].xdata = p0_in;
            end
            if (m[i].ph == a + s) m[i].active = 1'b0;
            else m[i].ph++;
        end else if (fetch_req || x_req) begin
            if (fetch_req && x_req) take_x = !m[i].last_x;
            else take_x = x_req;
            m[i].active = 1'b1;
            m[i].ph     = 0;
            m[i].last_x = take_x;
            if (take_x) begin
                m[i].op    = x_we ? 2 : 1;
                m[i].addr  = x_addr;
                m[i].wdata = x_wdata;
            end else begin
                m[i].op   = 0;
                m[i].addr = fetch_addr;
            end
        end
    endtask

    task automatic model_check(input int i);
        outs_t o = (i == 0) ? o0 : o1;
        outs_t e;
        int    a = a_of(i);
        int    s = s_of(i);
        string u = (i == 0) ? "u0" : "u1";
        e = '0;
        e.psen_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.fetch_data = m[i].fdata;
        e.x_rdata    = m[i].xdata;
        e.busy       = m[i].active;
        if (m[i].active) begin
            e.p2_out = m[i].addr[15:8];
            if (m[i].ph < a) begin
                e.ale = 1'b1; e.p0_oe = 1'b1; e.p0_out = m[i].addr[7:0];
                if (m[i].ph == 0) begin
                    if (m[i].op == 0) e.fetch_gnt = 1'b1; else e.x_gnt = 1'b1;
                end
            end else if (m[i].ph < a + s) begin
                if (m[i].op == 0) e.psen_n = 1'b0;
                else if (m[i].op == 1) e.rd_n = 1'b0;
                else begin e.wr_n = 1'b0; e.p0_oe = 1'b1; e.p0_out = m[i].wdata; end
            end else begin
                if (m[i].op == 0) e.fetch_done = 1'b1; else e.x_done = 1'b1;
                if (m[i].op == 2) begin e.p0_oe = 1'b1; e.p0_out = m[i].wdata; end
            end
        end
        chk({u, ".fetch_gnt"},  32'(o.fetch_gnt),  32'(e.fetch_gnt));
        chk({u, ".fetch_done"}, 32'(o.fetch_done), 32'(e.fetch_done));
        chk({u, ".fetch_data"}, 32'(o.fetch_data), 32'(e.fetch_data));
        chk({u, ".x_gnt"},      32'(o.x_gnt),      32'(e.x_gnt));
        chk({u, ".x_done"},     32'(o.x_done),     32'(e.x_done));
        chk({u, ".x_rdata"},    32'(o.x_rdata),    32'(e.x_rdata));
        chk({u, ".p0_out"},     32'(o.p0_out),     32'(e.p0_out));
        chk({u, ".p0_oe"},      32'(o.p0_oe),      32'(e.p0_oe));
        chk({u, ".p2_out"},     32'(o.p2_out),     32'(e.p2_out));
        chk({u, ".ale"},        32'(o.ale),        32'(e.ale));
        chk({u, ".psen_n"},     32'(o.psen_n),     32'(e.psen_n));
        chk({u, ".rd_n"},       32'(o.rd_n),       32'(e.rd_n));
        chk({u, ".wr_n"},       32'(o.wr_n),       32'(e.wr_n));
        chk({u, ".busy"},       32'(o.busy),       32'(e.busy));
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        cyc++;
        if (chk_en) for (int i = 0; i < 2; i++) model_check(i);
    endtask

    // Runs one access on u0 from the current request until its done pulse, dropping requests at grant.
    task automatic run_access(input logic [15:0] addr, input logic [7:0] wd, output int gap,
                              output int ale_ok, output int strb_n, output int wdat_ok,
                              output logic [2:0] mask);
        int g = -1;
        gap = -1; ale_ok = 0; strb_n = 0; wdat_ok = 0; mask = 3'b000;
        for (int k = 0; k < 40 && gap < 0; k++) begin
            step();
            if (o0.fetch_gnt || o0.x_gnt) begin
                g = k; fetch_req = 1'b0; x_req = 1'b0;
            end
            if (o0.ale && o0.p0_out == addr[7:0] && o0.p2_out == addr[15:8]) ale_ok++;
            if (!(o0.psen_n && o0.rd_n && o0.wr_n)) begin
                strb_n++;
                mask = mask | {~o0.psen_n, ~o0.rd_n, ~o0.wr_n};
            end
            if (!o0.wr_n && o0.p0_oe && o0.p0_out == wd) wdat_ok++;
            if ((o0.fetch_done || o0.x_done) && g >= 0) gap = k - g;
        end
        chk("access_done_seen", 32'(gap >= 0), 32'd1);
    endtask

    task automatic wait_gnt(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = o0.fetch_gnt || o0.x_gnt;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, ale_ok, strb_n, wdat_ok, cnt_x, overlap;
        logic [2:0] mask;
        bit outstanding;
        int order[$];
        int g0[$];
        int g1[$];
        int d1[$];

        reset = 1'b1; fetch_req = 1'b0; x_req = 1'b0; x_we = 1'b0;
        fetch_addr = '0; x_addr = '0; x_wdata = '0; p0_in = '0;
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};
        step(); step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Fetch from 1234 with A5 on the pads
        fetch_addr = 16'h1234; p0_in = 8'hA5; fetch_req = 1'b1;
        run_access(16'h1234, 8'h00, gap, ale_ok, strb_n, wdat_ok, mask);
        chk("t1_gnt_to_done", 32'(gap), 32'd5);
        chk("t1_ale_cycles", 32'(ale_ok), 32'd2);
        chk("t1_strobe_cycles", 32'(strb_n), 32'd3);
        chk("t1_strobe_which", 32'(mask), 32'b100);
        chk("t1_fetch_data", 32'(o0.fetch_data), 32'hA5);
        repeat (2) step();

        // MOVX write 80F0 <- 3C
        x_addr = 16'h80F0; x_wdata = 8'h3C; x_we = 1'b1; p0_in = 8'h11; x_req = 1'b1;
        run_access(16'h80F0, 8'h3C, gap, ale_ok, strb_n, wdat_ok, mask);
        chk("t2_gnt_to_done", 32'(gap), 32'd5);
        chk("t2_ale_cycles", 32'(ale_ok), 32'd2);
        chk("t2_strobe_which", 32'(mask), 32'b001);
        chk("t2_wdata_cycles", 32'(wdat_ok), 32'd3);
        chk("t2_hold_oe", 32'(o0.p0_oe), 32'd1);
        chk("t2_hold_data", 32'(o0.p0_out), 32'h3C);
        repeat (2) step();

        // Both requesters held from reset: strict alternation starting with MOVX
        reset = 1'b1; step(); reset = 1'b0;
        fetch_addr = 16'h0100; x_addr = 16'h2200; x_we = 1'b0; p0_in = 8'h5E;
        fetch_req = 1'b1; x_req = 1'b1;
        overlap = 0; outstanding = 1'b0;
        for (int k = 0; k < 60 && order.size() < 4; k++) begin
            step();
            if (o0.x_gnt || o0.fetch_gnt) begin
                if (outstanding) overlap++;
                outstanding = 1'b1;
                order.push_back(o0.x_gnt ? 1 : 0);
            end
            if (o0.fetch_done || o0.x_done) outstanding = 1'b0;
        end
        fetch_req = 1'b0; x_req = 1'b0;
        chk("t3_grant_count", 32'(order.size()), 32'd4);
        for (int j = 0; j < order.size(); j++) chk($sformatf("t3_order%0d", j), 32'(order[j]), 32'((j % 2) == 0));
        chk("t3_overlap", 32'(overlap), 32'd0);
        repeat (10) step();

        // Reset during the second strobe cycle of a read
        x_addr = 16'h4455; x_we = 1'b0; p0_in = 8'h5A; x_req = 1'b1;
        run_access(16'h4455, 8'h00, gap, ale_ok, strb_n, wdat_ok, mask);
        chk("t4_first_read", 32'(o0.x_rdata), 32'h5A);
        repeat (2) step();
        x_addr = 16'h4466; p0_in = 8'hC3; x_req = 1'b1;
        wait_gnt("t4_gnt_seen");
        x_req = 1'b0;
        repeat (3) step();
        chk("t4_rd_low_before", 32'(o0.rd_n), 32'd0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t4_rd_n_after", 32'(o0.rd_n), 32'd1);
        chk("t4_busy_after", 32'(o0.busy), 32'd0);
        chk("t4_rdata_kept", 32'(o0.x_rdata), 32'h5A);
        cnt_x = 0;
        for (int k = 0; k < 6; k++) begin step(); if (o0.x_done) cnt_x++; end
        chk("t4_no_done", 32'(cnt_x), 32'd0);

        // One-cycle MOVX pulse while a fetch is in flight
        fetch_addr = 16'h0ABC; p0_in = 8'h77; fetch_req = 1'b1;
        wait_gnt("t5_gnt_seen");
        fetch_req = 1'b0; x_req = 1'b1; x_we = 1'b0;
        step();
        x_req = 1'b0;
        cnt_x = 0;
        for (int k = 0; k < 12; k++) begin step(); if (o0.x_gnt) cnt_x++; end
        chk("t5_no_x_gnt", 32'(cnt_x), 32'd0);
        chk("t5_fetch_data", 32'(o0.fetch_data), 32'h77);

        // Held fetch request: back-to-back periods on both instances
        fetch_addr = 16'h0F00; p0_in = 8'h99; fetch_req = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (o0.fetch_gnt) g0.push_back(cyc);
            if (o1.fetch_gnt) g1.push_back(cyc);
            if (o1.fetch_done) d1.push_back(cyc);
        end
        fetch_req = 1'b0;
        chk("t6_u1_grants", 32'(g1.size() >= 3), 32'd1);
        chk("t6_u0_grants", 32'(g0.size() >= 2), 32'd1);
        if (g1.size() >= 3 && d1.size() >= 1) begin
            chk("t6_u1_period_a", 32'(g1[1] - g1[0]), 32'd4);
            chk("t6_u1_period_b", 32'(g1[2] - g1[1]), 32'd4);
            chk("t6_u1_latency", 32'(d1[0] - g1[0]), 32'd2);
        end
        if (g0.size() >= 2) chk("t6_u0_period", 32'(g0[1] - g0[0]), 32'd7);
        repeat (10) step();

        // Random traffic against the model, with occasional resets
        for (int k = 0; k < 500; k++) begin
            fetch_req  = ($urandom_range(0, 3) != 0);
            x_req      = ($urandom_range(0, 2) == 0);
            x_we       = 1'($urandom_range(0, 1));
            fetch_addr = 16'($urandom);
            x_addr     = 16'($urandom);
            x_wdata    = 8'($urandom);
            p0_in      = 8'($urandom);
            reset      = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0; fetch_req = 1'b0; x_req = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
